cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter Entry_Width, default 4, SHALL set the ROB entry tag width.
REQ-002 Parameter Data_Width, default 32, SHALL set the result value width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 flush  input  1  SHALL be the synchronous pipeline flush from ROB (active-high).
REQ-006 alu_valid  input  1  SHALL be the ALU result-pending flag.
REQ-007 alu_entry  input  Entry_Width  SHALL be the ALU destination ROB entry.
REQ-008 alu_value  input  Data_Width  SHALL be the ALU result.
REQ-009 alu_ready  output  1  SHALL be the ALU grant (combinational).
REQ-010 ld_valid, ld_entry, ld_value (inputs) and ld_ready (output) SHALL mirror REQ-006..009 for the Load unit.
REQ-011 br_valid, br_entry, br_value (inputs) and br_ready (output) SHALL mirror REQ-006..009 for the Branch unit.
REQ-012 cdb_valid  output  1  SHALL be the registered broadcast strobe to ROB and reservation stations.
REQ-013 cdb_entry  output  Entry_Width  SHALL be the registered broadcast ROB entry.
REQ-014 cdb_value  output  Data_Width  SHALL be the registered broadcast value.

Function
REQ-015 Requesters SHALL be indexed ALU=0, Load=1, Branch=2; a 2-bit round-robin pointer ptr SHALL hold the highest-priority index.
REQ-016 Each cycle, if flush=0, the arbiter SHALL assert exactly one x_ready: that of the first requester with x_valid=1, searching ptr, ptr+1, ptr+2 (mod 3).
REQ-017 If no x_valid is high, or flush=1, all x_ready SHALL be 0.
REQ-018 A transfer SHALL occur on an edge where x_valid=1 and x_ready=1; at most one transfer per cycle.
REQ-019 On a transfer at edge t, cdb_valid SHALL be 1 and cdb_entry/cdb_value SHALL equal the granted payload for the cycle after edge t (latency one cycle, throughput one result per cycle).
REQ-020 On an edge with no transfer, cdb_valid SHALL be 0; cdb_entry/cdb_value SHALL hold their previous values.
REQ-021 After a transfer from index g, ptr SHALL become (g+1) mod 3; with no transfer ptr SHALL be unchanged.
REQ-022 Sources SHALL hold x_valid and payload stable until their ready is seen; x_valid SHALL NOT depend combinationally on x_ready; the arbiter SHALL NOT drop or duplicate a held request.
REQ-023 x_ready SHALL depend only on x_valid inputs, flush, and ptr (no payload dependence).
REQ-024 flush=1 at an edge SHALL force cdb_valid=0 in the following cycle and set ptr to 0; requests present during flush SHALL be ignored (sources discard them).
REQ-025 A requester held valid SHALL be granted within 3 cycles of assertion (no starvation) while flush=0.
REQ-026 ptr value 3 SHALL never occur; if reached, it SHALL be treated as 0 and reloaded to 0 at the next edge.

Reset
REQ-027 While rst=0, asynchronously: cdb_valid=0, cdb_entry=0, cdb_value=0, ptr=0; all x_ready SHALL be 0.
REQ-028 After rst rises, the first edge SHALL behave per REQ-016 with ptr=0 (ALU highest priority).
REQ-029 Reset asserted mid-transfer SHALL discard the in-flight broadcast; cdb_valid SHALL be 0 immediately.

Verification
REQ-030 Reset release, only alu_valid=1, entry=5, value=0x0000_00AA -> alu_ready=1 same cycle; next cycle cdb_valid=1, cdb_entry=5, cdb_value=0xAA; ptr=1.
REQ-031 All three valid and held from ptr=0 (entries 1,2,3) -> grants ALU, Load, Branch on consecutive cycles; cdb_entry 1,2,3 on three consecutive cycles, cdb_valid continuously 1.
REQ-032 ALU and Load continuously valid, ptr=0 -> grants alternate ALU, Load, ALU, Load; Branch asserted later granted within 3 cycles.
REQ-033 Transfer at edge t with flush=1 at edge t+1 while Load valid -> cdb_valid=1 after t, cdb_valid=0 after t+1, ld_ready=0 during flush, ptr=0 after t+1.
REQ-034 rst driven low between edges while cdb_valid=1 -> cdb_valid, cdb_entry, cdb_value go to 0 without a clock edge; all ready=0.
REQ-035 No valid for 4 cycles after a Branch grant -> cdb_valid=0, cdb_entry/cdb_value unchanged, ptr remains 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one of ALU/Load/Branch results per cycle
// with round-robin fairness and broadcasts it, registered, to ROB and RS.
//
// Ports:
//   clk, rst (async, active-low), flush (sync, active-high)
//   alu_/ld_/br_ valid, entry, value  : result requests from each unit
//   alu_/ld_/br_ ready                : combinational grants
//   cdb_valid, cdb_entry, cdb_value   : registered broadcast
module cdb_arbiter #(
    parameter int Entry_Width = 4,
    parameter int Data_Width  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,

    input  logic                   alu_valid,
    input  logic [Entry_Width-1:0] alu_entry,
    input  logic [Data_Width-1:0]  alu_value,
    output logic                   alu_ready,

    input  logic                   ld_valid,
    input  logic [Entry_Width-1:0] ld_entry,
    input  logic [Data_Width-1:0]  ld_value,
    output logic                   ld_ready,

    input  logic                   br_valid,
    input  logic [Entry_Width-1:0] br_entry,
    input  logic [Data_Width-1:0]  br_value,
    output logic                   br_ready,

    output logic                   cdb_valid,
    output logic [Entry_Width-1:0] cdb_entry,
    output logic [Data_Width-1:0]  cdb_value
);

    localparam logic [1:0] IdxAlu = 2'd0;
    localparam logic [1:0] IdxLd  = 2'd1;
    localparam logic [1:0] IdxBr  = 2'd2;

    // Highest-priority requester index
    logic [1:0] ptr;
    logic [1:0] eff_ptr;

    logic [2:0] valid_vec;
    logic       any_valid;
    logic [1:0] grant_idx;
    logic [2:0] grant_vec;
    logic       transfer;
    logic [1:0] ptr_next;

    logic [Entry_Width-1:0] sel_entry;
    logic [Data_Width-1:0]  sel_value;

    assign valid_vec = {br_valid, ld_valid, alu_valid};
    assign any_valid = |valid_vec;

    // The illegal encoding 3 behaves as 0 until it is reloaded
    assign eff_ptr = (ptr == 2'd3) ? IdxAlu : ptr;

    // Rotating search starting at eff_ptr
    always_comb begin
        grant_idx = IdxAlu;
        case (eff_ptr)
            IdxLd: begin
                if (valid_vec[1])      grant_idx = IdxLd;
                else if (valid_vec[2]) grant_idx = IdxBr;
                else                   grant_idx = IdxAlu;
            end
            IdxBr: begin
                if (valid_vec[2])      grant_idx = IdxBr;
                else if (valid_vec[0]) grant_idx = IdxAlu;
                else                   grant_idx = IdxLd;
            end
            default: begin
                if (valid_vec[0])      grant_idx = IdxAlu;
                else if (valid_vec[1]) grant_idx = IdxLd;
                else                   grant_idx = IdxBr;
            end
        endcase
    end

    // Grants are suppressed during reset and flush
    assign transfer  = rst & ~flush & any_valid;
    assign grant_vec = transfer ? (3'b001 << grant_idx) : 3'b000;

    assign alu_ready = grant_vec[0];
    assign ld_ready  = grant_vec[1];
    assign br_ready  = grant_vec[2];

    assign ptr_next = (grant_idx == IdxBr) ? IdxAlu : grant_idx + 2'd1;

    always_comb begin
        sel_entry = '0;
        sel_value = '0;
        unique case (1'b1)
            grant_vec[0]: begin
                sel_entry = alu_entry;
                sel_value = alu_value;
            end
            grant_vec[1]: begin
                sel_entry = ld_entry;
                sel_value = ld_value;
            end
            grant_vec[2]: begin
                sel_entry = br_entry;
                sel_value = br_value;
            end
            default: begin
                sel_entry = '0;
                sel_value = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_entry <= '0;
            cdb_value <= '0;
            ptr       <= IdxAlu;
        end else if (flush) begin
            cdb_valid <= 1'b0;
            ptr       <= IdxAlu;
        end else if (transfer) begin
            cdb_valid <= 1'b1;
            cdb_entry <= sel_entry;
            cdb_value <= sel_value;
            ptr       <= ptr_next;
        end else begin
            cdb_valid <= 1'b0;
            ptr       <= eff_ptr;
        end
    end

endmodule
